// File: rtl/aes_byte_loader.sv
// Byte-serial frame driver for the AES core input port:
// sync strobe, data block, key size, key bytes, mode byte.
module aes_byte_loader #(
    parameter int DATA_BYTES = 16,
    parameter int KEY_MAX    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic [8*KEY_MAX-1:0]    key_in,
    input  logic [6:0]              key_bytes,
    input  logic                    encrypt,
    output logic                    we,
    output logic [7:0]              Outdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int KW = 8 * KEY_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_DATA, S_KSIZE, S_KEY, S_MODE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic [KW-1:0]   key_q, key_d;
    logic [6:0]      kb_q, kb_d;
    logic            enc_q, enc_d;
    logic            we_q, we_d;
    logic [7:0]      out_q, out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            legal;
    logic [6:0]      pad;

    assign legal = (key_bytes == 7'd16) || (key_bytes == 7'd24) ||
                   (key_bytes == 7'd32);
    assign pad   = 7'(KEY_MAX) - key_bytes;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        kb_d    = kb_q;
        enc_d   = enc_q;
        we_d    = 1'b0;
        out_d   = 8'h00;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start && legal) begin
                    state_d = S_SYNC;
                    data_d  = data_in;
                    // Left-justify so the top byte is always the next to send
                    key_d   = key_in << {pad, 3'b000};
                    kb_d    = key_bytes;
                    enc_d   = encrypt;
                    cnt_d   = 6'd0;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            S_SYNC: begin
                state_d = S_DATA;
                out_d   = data_q[DW-1 -: 8];
                data_d  = data_q << 8;
                cnt_d   = 6'd1;
            end
            S_DATA: begin
                if (cnt_q == 6'(DATA_BYTES)) begin
                    state_d = S_KSIZE;
                    out_d   = {1'b0, kb_q};
                    cnt_d   = 6'd0;
                end else begin
                    out_d  = data_q[DW-1 -: 8];
                    data_d = data_q << 8;
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            S_KSIZE: begin
                state_d = S_KEY;
                out_d   = key_q[KW-1 -: 8];
                key_d   = key_q << 8;
                cnt_d   = 6'd1;
            end
            S_KEY: begin
                if ({1'b0, cnt_q} == kb_q) begin
                    state_d = S_MODE;
                    out_d   = {7'b0, enc_q};
                end else begin
                    out_d = key_q[KW-1 -: 8];
                    key_d = key_q << 8;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_MODE: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            kb_q    <= '0;
            enc_q   <= 1'b0;
            we_q    <= 1'b0;
            out_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            kb_q    <= kb_d;
            enc_q   <= enc_d;
            we_q    <= we_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign we      = we_q;
    assign Outdata = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
